countdown_sequencer: RTL and testbench
======================================

// Module: countdown_sequencer
// PURPOSE
//  Controller that sequences one Problema3-style down counter (load via reset, decrement pulse).
//  Latches a start value and a tick period, reloads the counter, and issues paced decrement pulses.
//  Supports pause/resume and abort, and flags completion when the counter reaches zero.
//  Sits between user control logic and the counter instance; the counter's out feeds back as ctr_val.
// PARAMETERS
//  N        6  counter width (matches counter N)
//  PRESC_W  4  width of tick-period field / internal prescaler
// PORTS
//  clk          in   1        system clock, all logic on rising edge
//  rst          in   1        synchronous, active-low reset (rst=0 resets on next clk edge)
//  start        in   1        request a new countdown; sampled only in IDLE
//  pause        in   1        level; holds countdown while 1 (RUN<->PAUSE)
//  abort        in   1        level; cancels active countdown, no done
//  inicial      in   N        start value, latched when start accepted
//  period       in   PRESC_W  decrement every period+1 cycles; latched with start
//  ctr_val      in   N        counter's current out
//  ctr_rst      out  1        active-high reset/load to counter (loads ctr_inicial)
//  ctr_inicial  out  N        value driven to counter's inicial input
//  decrementar  out  1        one-cycle decrement pulse to counter
//  busy         out  1        1 in LOAD/RUN/PAUSE
//  done         out  1        one-cycle pulse on completion
//  state        out  3        IDLE=0 LOAD=1 RUN=2 PAUSE=3 DONE=4
// BEHAVIOUR
//  Reset (rst=0): state=IDLE, prescaler=0, ctr_inicial=0, decrementar=0, busy=0, done=0.
//   ctr_rst = ~rst | (state==LOAD), combinational, so the counter is held in reset during our reset.
//  IDLE: start=1 -> latch inicial/period, go LOAD. Otherwise stay.
//  LOAD (1 cycle): ctr_rst=1, ctr_inicial=latched value; prescaler<=0.
//   Latched inicial==0 -> DONE; else -> RUN. Counter shows the loaded value on the first RUN cycle.
//  RUN, priority highest first:
//   abort -> IDLE. ctr_val==0 -> DONE. pause -> PAUSE (prescaler held).
//   Else tick: if prescaler==period and ctr_val!=0, decrementar=1 and prescaler<=0; otherwise prescaler+1.
//  PAUSE: decrementar=0, prescaler frozen. abort -> IDLE (wins). pause=0 -> RUN, resumes from held count.
//  DONE (1 cycle): done=1 -> IDLE.
//  decrementar is never asserted outside RUN, and never when ctr_val==0 (no wrap below 0).
//  start is ignored outside IDLE, including in DONE. New latched values apply only on the next accepted start.
//  Abort leaves the counter value as-is; the next start reloads it.
//  Timing, start sampled at edge 0, K=inicial>0, P=period: LOAD cycle 1, RUN from cycle 2.
//   j-th decrementar at cycle 1+j*(P+1). done at cycle K*(P+1)+3.
//   K=0 gives done at cycle 2. Each pause cycle adds one cycle.
//  rst=0 mid-operation: state IDLE at the next edge; no done pulse.
//  Prescaler compares by equality on PRESC_W bits: period=0 gives a decrement every cycle; max period=2^PRESC_W-1.
// TESTING
//  Bench instantiates Problema3 (N=6) driven by ctr_rst/ctr_inicial/decrementar, feeding back ctr_val.
//  1 Reset: rst=0 for 2 cycles -> state=0, busy=0, done=0, decrementar=0, ctr_rst=1.
//  2 inicial=3, period=1, start pulse -> decrementar at cycles 3,5,7; ctr_val 3,2,1,0.
//    done at cycle 9; busy=1 cycles 1..8.
//  3 inicial=4, period=0, pause=1 for 3 cycles after the 2nd decrement:
//    ctr_val holds 2, no decrementar, state=3; done at cycle 10 instead of 7.
//  4 inicial=37 (6'b100101), period=2, abort after 4 decrements:
//    IDLE next cycle, done never asserted, ctr_val stays 33; new start reloads 37.
//  5 inicial=0, start -> done at cycle 2, decrementar never asserted.
//  6 start pulsed during RUN -> ignored, counting continues.
//    rst=0 mid-RUN -> state=IDLE next edge, ctr_rst=1, no done.

Source files
------------

// File: rtl/countdown_sequencer.sv
// Sequencer for an external load/decrement down counter: latches a start value and tick
// period, reloads the counter, paces decrement pulses, and supports pause and abort.
module countdown_sequencer #(
  parameter int N       = 6,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [N-1:0]       inicial,
  input  logic [PRESC_W-1:0] period,
  input  logic [N-1:0]       ctr_val,
  output logic               ctr_rst,
  output logic [N-1:0]       ctr_inicial,
  output logic               decrementar,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [N-1:0]         r_inicial;
  logic [PRESC_W-1:0]   r_period;
  logic [PRESC_W-1:0]   r_presc;
  logic [PRESC_W-1:0]   w_presc_next;
  logic                 w_dec;
  logic                 w_ctr_zero;

  assign w_ctr_zero = (ctr_val == '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_presc   <= '0;
      r_inicial <= '0;
      r_period  <= '0;
    end else begin
      r_state <= w_next;
      r_presc <= w_presc_next;
      if (r_state == S_IDLE && start) begin
        r_inicial <= inicial;
        r_period  <= period;
      end
    end
  end

  // RUN priority: abort, then completion, then pause, then the prescaler tick.
  always_comb begin
    w_next       = r_state;
    w_presc_next = r_presc;
    w_dec        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_presc_next = '0;
        w_next       = (r_inicial == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          w_next = S_IDLE;
        end else if (w_ctr_zero) begin
          w_next = S_DONE;
        end else if (pause) begin
          w_next = S_PAUSE;
        end else if (r_presc == r_period) begin
          w_dec        = 1'b1;
          w_presc_next = '0;
        end else begin
          w_presc_next = r_presc + 1'b1;
        end
      end
      S_PAUSE: begin
        if (abort)       w_next = S_IDLE;
        else if (!pause) w_next = S_RUN;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // The counter is held in load while we are in reset so both come up consistent.
  assign ctr_rst     = ~rst | (r_state == S_LOAD);
  assign ctr_inicial = r_inicial;
  assign decrementar = w_dec & rst;
  assign busy        = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_PAUSE);
  assign done        = (r_state == S_DONE);
  assign state       = r_state;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Scoreboard bench: stimulus pushes expected decrement/done events; a negedge monitor pops
// and compares them against the DUT driving a behavioural model of the down counter.
module tb_countdown_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic [5:0] inicial = '0;
  logic [3:0] period = '0;
  logic [5:0] ctr_val;
  logic       ctr_rst;
  logic [5:0] ctr_inicial;
  logic       decrementar;
  logic       busy;
  logic       done;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;

  typedef struct {
    int         cy;
    bit         dn;
    logic [5:0] val;
  } ev_t;
  ev_t q[$];

  countdown_sequencer #(.N(6), .PRESC_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .inicial(inicial), .period(period), .ctr_val(ctr_val),
    .ctr_rst(ctr_rst), .ctr_inicial(ctr_inicial), .decrementar(decrementar),
    .busy(busy), .done(done), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Problema3-style counter: active-high load, decrement on pulse.
  always @(posedge clk) begin
    if (ctr_rst)          ctr_val <= ctr_inicial;
    else if (decrementar) ctr_val <= ctr_val - 6'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc - base);
    end
  endtask

  task automatic exp_ev(input int c, input bit dn, input logic [5:0] v);
    ev_t e;
    e.cy  = base + c;
    e.dn  = dn;
    e.val = v;
    q.push_back(e);
  endtask

  // Monitor: every decrement or done pulse must match the head of the queue.
  always @(negedge clk) begin
    if (decrementar === 1'b1 || done === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL event: unexpected dec=%0b done=%0b at cycle %0d", decrementar, done, cyc - base);
      end else begin
        ev_t e;
        e = q.pop_front();
        if (e.cy != cyc || e.dn != done || e.dn == decrementar || e.val !== ctr_val) begin
          errors++;
          $display("FAIL event: got cycle %0d done=%0b ctr_val=%0d expected cycle %0d done=%0b ctr_val=%0d",
                   cyc - base, done, ctr_val, e.cy - base, e.dn, e.val);
        end
      end
    end
  end

  // Position at posedge+1 inside relative cycle c.
  task automatic goto(input int c);
    int guard;
    guard = 0;
    while (cyc < base + c && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) begin
      checks++;
      errors++;
      $display("FAIL timeout: got cycle %0d expected cycle %0d", cyc - base, c);
    end
  endtask

  task automatic start_run(input logic [5:0] k, input logic [3:0] p);
    inicial = k;
    period  = p;
    start   = 1'b1;
    base    = cyc;
    @(posedge clk);
    #1;
    start   = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk_drained(input string nm);
    chk(nm, q.size(), 0);
  endtask

  initial begin
    // 1: reset
    base = 0;
    repeat (2) @(posedge clk);
    #1;
    sample();
    chk("rst_state", state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dec", decrementar, 0);
    chk("rst_ctr_rst", ctr_rst, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sample();
    chk("rst_release_ctr_rst", ctr_rst, 0);
    @(posedge clk);
    #1;

    // 2: K=3, P=1
    start_run(6'd3, 4'd1);
    exp_ev(3, 0, 6'd3);
    exp_ev(5, 0, 6'd2);
    exp_ev(7, 0, 6'd1);
    exp_ev(9, 1, 6'd0);
    sample();
    chk("t2_load_state", state, 1);
    chk("t2_load_busy", busy, 1);
    chk("t2_load_ctr_rst", ctr_rst, 1);
    chk("t2_load_inicial", ctr_inicial, 3);
    goto(2); sample();
    chk("t2_run_ctr_val", ctr_val, 3);
    goto(8); sample();
    chk("t2_busy_c8", busy, 1);
    goto(9); sample();
    chk("t2_busy_c9", busy, 0);
    chk("t2_state_c9", state, 4);
    goto(11); sample();
    chk("t2_idle", state, 0);
    chk_drained("t2_drained");

    // 3: K=4, P=0, pause after the 2nd decrement
    @(posedge clk); #1;
    start_run(6'd4, 4'd0);
    exp_ev(2, 0, 6'd4);
    exp_ev(3, 0, 6'd3);
    exp_ev(7, 0, 6'd2);
    exp_ev(8, 0, 6'd1);
    exp_ev(10, 1, 6'd0);
    goto(4);
    pause = 1'b1;
    sample();
    chk("t3_ctr_c4", ctr_val, 2);
    goto(5); sample();
    chk("t3_state_c5", state, 3);
    chk("t3_ctr_c5", ctr_val, 2);
    goto(6);
    pause = 1'b0;
    sample();
    chk("t3_state_c6", state, 3);
    chk("t3_ctr_c6", ctr_val, 2);
    goto(12); sample();
    chk_drained("t3_drained");

    // 4: K=37, P=2, abort after 4 decrements, then reload
    start_run(6'd37, 4'd2);
    exp_ev(4, 0, 6'd37);
    exp_ev(7, 0, 6'd36);
    exp_ev(10, 0, 6'd35);
    exp_ev(13, 0, 6'd34);
    goto(14);
    abort = 1'b1;
    sample();
    chk("t4_ctr_c14", ctr_val, 33);
    goto(15);
    abort = 1'b0;
    sample();
    chk("t4_state_c15", state, 0);
    goto(18); sample();
    chk("t4_ctr_hold", ctr_val, 33);
    chk_drained("t4_drained");
    @(posedge clk); #1;
    start_run(6'd37, 4'd2);
    goto(2); sample();
    chk("t4_reload", ctr_val, 37);
    goto(3);
    abort = 1'b1;
    goto(4);
    abort = 1'b0;
    sample();
    chk("t4_abort2_state", state, 0);

    // 5: K=0
    @(posedge clk); #1;
    start_run(6'd0, 4'd3);
    exp_ev(2, 1, 6'd0);
    sample();
    chk("t5_load_state", state, 1);
    goto(5); sample();
    chk("t5_idle", state, 0);
    chk_drained("t5_drained");

    // 6: start ignored in RUN, then reset mid-RUN
    start_run(6'd5, 4'd0);
    exp_ev(2, 0, 6'd5);
    exp_ev(3, 0, 6'd4);
    exp_ev(4, 0, 6'd3);
    goto(3);
    inicial = 6'd20;
    start   = 1'b1;
    goto(4);
    start   = 1'b0;
    sample();
    chk("t6_state_c4", state, 2);
    goto(5);
    rst = 1'b0;
    sample();
    chk("t6_rst_ctr_rst", ctr_rst, 1);
    chk("t6_rst_dec", decrementar, 0);
    goto(6);
    rst = 1'b1;
    sample();
    chk("t6_state_c6", state, 0);
    chk("t6_busy_c6", busy, 0);
    goto(9); sample();
    chk_drained("t6_drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
